// File: rtl/prog_instruction_memory.sv
// rtl/prog_instruction_memory.sv - byte-loadable instruction memory with NOP-guarded fetch port.
// Optional image checksum on chk is built when PROG_IMEM_CHECKSUM_EN is defined.
module prog_instruction_memory #(
  parameter int          DEPTH    = 128,
  parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                a,
  output logic [31:0]                rd,
  output logic                       misaligned,
  input  logic                       ld_start,
  input  logic                       ld_valid,
  input  logic [7:0]                 ld_byte,
  output logic                       ld_ready,
  input  logic                       ld_done,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] wcount,
  output logic [31:0]                chk
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_mem [DEPTH];
  logic [CW-1:0] r_wcount;
  logic [CW-1:0] r_wcount_valid;
  logic [1:0]    r_bcnt;
  logic [31:0]   r_asm;
  logic          r_overflow;

  logic          w_full;
  logic          w_restart;
  logic          w_accept;
  logic          w_word_wr;
  logic          w_pad_wr;
  logic          w_pad_drop;
  logic          w_we;
  logic [31:0]   w_asm_nxt;
  logic [31:0]   w_wdata;
  logic [29:0]   w_idx;

  assign w_full     = (r_wcount >= FULL);
  assign ld_ready   = (r_state == S_LOAD) && !w_full;
  assign busy       = (r_state == S_LOAD) || (r_state == S_COMMIT);
  assign w_restart  = ld_start && (r_state != S_COMMIT);
  // A restart cycle never takes a byte, even if one is offered.
  assign w_accept   = (r_state == S_LOAD) && !ld_start && ld_valid && ld_ready;
  assign w_word_wr  = w_accept && (r_bcnt == 2'd3);
  assign w_pad_wr   = (r_state == S_COMMIT) && (r_bcnt != 2'd0) && !w_full;
  assign w_pad_drop = (r_state == S_COMMIT) && (r_bcnt != 2'd0) && w_full;
  assign w_we       = w_word_wr || w_pad_wr;
  assign w_wdata    = w_word_wr ? w_asm_nxt : r_asm;

  // Bytes above the fill point stay zero, so the assembly register doubles as the padded word.
  always_comb begin
    w_asm_nxt = r_asm;
    case (r_bcnt)
      2'd0:    w_asm_nxt = {24'h000000, ld_byte};
      2'd1:    w_asm_nxt[15:8]  = ld_byte;
      2'd2:    w_asm_nxt[23:16] = ld_byte;
      default: w_asm_nxt[31:24] = ld_byte;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (ld_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (ld_start)     w_state_nxt = S_LOAD;
        else if (ld_done) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wcount       <= '0;
      r_wcount_valid <= '0;
      r_bcnt         <= 2'd0;
      r_asm          <= 32'h0;
      r_overflow     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_restart) begin
        r_wcount   <= '0;
        r_bcnt     <= 2'd0;
        r_asm      <= 32'h0;
        r_overflow <= 1'b0;
      end else if (r_state == S_LOAD) begin
        if (w_accept) begin
          r_bcnt <= r_bcnt + 2'd1;
          r_asm  <= (r_bcnt == 2'd3) ? 32'h0 : w_asm_nxt;
          if (r_bcnt == 2'd3) r_wcount <= r_wcount + 1'b1;
        end else if (ld_valid && w_full) begin
          r_overflow <= 1'b1;
        end
      end else if (r_state == S_COMMIT) begin
        r_bcnt <= 2'd0;
        r_asm  <= 32'h0;
        if (w_pad_wr) begin
          r_wcount       <= r_wcount + 1'b1;
          r_wcount_valid <= r_wcount + 1'b1;
        end else begin
          r_wcount_valid <= r_wcount;
        end
        if (w_pad_drop) r_overflow <= 1'b1;
      end
    end
  end

  // Array has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (!reset && w_we) r_mem[r_wcount[AW-1:0]] <= w_wdata;
  end

`ifdef PROG_IMEM_CHECKSUM_EN
  logic [31:0] r_chk;

  always_ff @(posedge clk) begin
    if (reset)          r_chk <= 32'h0;
    else if (w_restart) r_chk <= 32'h0;
    else if (w_we)      r_chk <= r_chk ^ w_wdata;
  end

  assign chk = r_chk;
`else
  assign chk = 32'h0;
`endif

  assign w_idx      = a[31:2];
  assign misaligned = (a[1:0] != 2'b00);
  assign overflow   = r_overflow;
  assign wcount     = r_wcount;

  always_comb begin
    rd = NOP_WORD;
    if (!busy && (w_idx < 30'(r_wcount_valid))) rd = r_mem[w_idx[AW-1:0]];
  end

endmodule

// File: tb/tb_prog_instruction_memory.sv
// tb/tb_prog_instruction_memory.sv - directed self-checking bench for prog_instruction_memory.
module tb_prog_instruction_memory;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_done;

  logic [31:0] rd, rd_s;
  logic        mis, mis_s;
  logic        rdy, rdy_s;
  logic        busy, busy_s;
  logic        ovf, ovf_s;
  logic [7:0]  wcnt;
  logic [2:0]  wcnt_s;
  logic [31:0] chk, chk_s;

  int checks;
  int failures;
  int first_low;

  localparam logic [31:0] NOP = 32'hE1A00000;

  prog_instruction_memory u_dut (
    .clk(clk), .reset(reset), .a(a), .rd(rd), .misaligned(mis),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(rdy),
    .ld_done(ld_done), .busy(busy), .overflow(ovf), .wcount(wcnt), .chk(chk)
  );

  prog_instruction_memory #(.DEPTH(4)) u_small (
    .clk(clk), .reset(reset), .a(a), .rd(rd_s), .misaligned(mis_s),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(rdy_s),
    .ld_done(ld_done), .busy(busy_s), .overflow(ovf_s), .wcount(wcnt_s), .chk(chk_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    check(tag, rd, exp);
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_byte  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic finish_load();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check("busy_in_commit", {31'h0, busy}, 32'h1);
    tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    a         = 32'h0;
    ld_start  = 1'b0;
    ld_valid  = 1'b0;
    ld_byte   = 8'h00;
    ld_done   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // reset state
    fetch("rst_rd_a0", 32'd0, NOP);
    fetch("rst_rd_a4", 32'd4, NOP);
    fetch("rst_rd_a400", 32'd400, NOP);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_wcount", {24'h0, wcnt}, 32'h0);
    check("rst_overflow", {31'h0, ovf}, 32'h0);
    check("rst_chk", chk, 32'h0);
    check("rst_ready", {31'h0, rdy}, 32'h0);

    // two full words
    start_load();
    check("load_busy", {31'h0, busy}, 32'h1);
    check("load_ready", {31'h0, rdy}, 32'h1);
    send(8'h78); send(8'h00); send(8'hA0); send(8'hE3);
    send(8'h4B); send(8'h1E); send(8'hA0); send(8'hE3);
    check("w2_wcount_load", {24'h0, wcnt}, 32'd2);
    fetch("w2_rd_busy", 32'd0, NOP);
    finish_load();
    check("w2_busy_idle", {31'h0, busy}, 32'h0);
    check("w2_wcount", {24'h0, wcnt}, 32'd2);
    fetch("w2_rd_a0", 32'd0, 32'hE3A00078);
    fetch("w2_rd_a4", 32'd4, 32'hE3A01E4B);
    fetch("w2_rd_a8", 32'd8, NOP);
`ifdef PROG_IMEM_CHECKSUM_EN
    check("w2_chk", chk, 32'h00001E33);
`else
    check("w2_chk", chk, 32'h0);
`endif

    // partial word padded at commit
    start_load();
    send(8'h01); send(8'h02); send(8'h03);
    check("pad_busy_load", {31'h0, busy}, 32'h1);
    check("pad_wcount_pre", {24'h0, wcnt}, 32'd0);
    finish_load();
    check("pad_busy_idle", {31'h0, busy}, 32'h0);
    check("pad_wcount", {24'h0, wcnt}, 32'd1);
    fetch("pad_rd_a0", 32'd0, 32'h00030201);
    fetch("pad_rd_a4", 32'd4, NOP);
`ifdef PROG_IMEM_CHECKSUM_EN
    check("pad_chk", chk, 32'h00030201);
`else
    check("pad_chk", chk, 32'h0);
`endif

    // overflow on the 4-word instance
    start_load();
    first_low = -1;
    for (int i = 0; i < 20; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'(i);
      if (!rdy_s && first_low < 0) first_low = i;
      tick();
    end
    ld_valid = 1'b0;
    check("ovf_ready_drop_at", 32'(first_low), 32'd16);
    check("ovf_small_flag", {31'h0, ovf_s}, 32'h1);
    check("ovf_small_wcount", {29'h0, wcnt_s}, 32'd4);
    check("ovf_big_flag", {31'h0, ovf}, 32'h0);
    check("ovf_big_wcount", {24'h0, wcnt}, 32'd5);
    finish_load();
    a = 32'd12;
    #1;
    check("ovf_small_rd_a12", rd_s, 32'h0F0E0D0C);
    check("ovf_small_flag_idle", {31'h0, ovf_s}, 32'h1);
    fetch("ovf_big_rd_a16", 32'd16, 32'h13121110);
    start_load();
    check("ovf_cleared", {31'h0, ovf_s}, 32'h0);
    check("ovf_wcount_clr", {29'h0, wcnt_s}, 32'd0);

    // restart mid-word
    send(8'hAA); send(8'hBB);
    ld_valid = 1'b1;
    ld_byte  = 8'hCC;
    start_load();
    ld_valid = 1'b0;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    finish_load();
    check("rst_mid_wcount", {24'h0, wcnt}, 32'd1);
    fetch("rst_mid_rd_a0", 32'd0, 32'h44332211);
    fetch("rst_mid_rd_a4", 32'd4, NOP);
`ifdef PROG_IMEM_CHECKSUM_EN
    check("rst_mid_chk", chk, 32'h44332211);
`else
    check("rst_mid_chk", chk, 32'h0);
`endif

    // inputs ignored in IDLE
    send(8'h55);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check("idle_ignore_busy", {31'h0, busy}, 32'h0);
    check("idle_ignore_wcount", {24'h0, wcnt}, 32'd1);

    // reset mid-load
    start_load();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    check("abort_wcount_pre", {24'h0, wcnt}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_wcount", {24'h0, wcnt}, 32'd0);
    check("abort_chk", chk, 32'h0);
    fetch("abort_rd_a0", 32'd0, NOP);
    a = 32'd2;
    #1;
    check("abort_misaligned", {31'h0, mis}, 32'h1);
    check("abort_rd_a2", rd, NOP);
    a = 32'd0;
    #1;
    check("aligned_flag", {31'h0, mis}, 32'h0);

    // misaligned fetch still returns the word
    start_load();
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    finish_load();
    fetch("mis_rd_a3", 32'd3, 32'hDEADBEEF);
    check("mis_flag_a3", {31'h0, mis}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
